// File: rtl/dmem_bank_sized.sv
// Clocked byte-addressed data memory with byte/half/word access, load extension,
// a configurable wait-state sequencer and a single-cycle ready/fault response.
module dmem_bank_sized #(
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              ready,
  output logic              fault
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WS_C  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Rejects out-of-range addresses, the reserved size and misaligned accesses.
  function automatic logic req_fault(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
    logic bad;
    bad = ((a >> (IDX_W + 2)) != '0);
    case (sz)
      2'b00:   bad = bad;
      2'b01:   bad = bad | a[0];
      2'b10:   bad = bad | (a[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  logic [31:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]  idx_s;
  logic [1:0]        lane_s;
  logic              fault_chk_s;
  logic              commit_s;
  logic              acc_ok_s;
  logic              we_s;
  logic [3:0]        be_s;
  logic [31:0]       wlane_s;
  logic [31:0]       word_s;

  assign idx_s       = addr_q[IDX_W+1:2];
  assign lane_s      = addr_q[1:0];
  assign fault_chk_s = req_fault(addr_q, size_q);
  assign commit_s    = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign acc_ok_s    = commit_s && !fault_chk_s;
  assign we_s        = acc_ok_s && wr_q && !rst;
  assign word_s      = mem_q[idx_s];

  // Lane steering of right-justified store data plus per-lane byte enables.
  always_comb begin
    be_s    = 4'b0000;
    wlane_s = wdata_q;
    case (size_q)
      2'b00: begin
        be_s    = 4'b0001 << lane_s;
        wlane_s = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wlane_s = wdata_q;
      end
      default: begin
        be_s    = 4'b0000;
        wlane_s = wdata_q;
      end
    endcase
  end

  // Array write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
        end
      end
    end
  end

  // Sequencer next state, request capture and response generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    fault_d    = 1'b0;
    readdata_d = readdata_q;
    case (state_q)
      S_IDLE: begin
        if (memread ^ memwrite) begin
          addr_d  = address;
          size_d  = size;
          uns_d   = unsigned_ld;
          wr_d    = memwrite;
          wdata_d = writedata;
          cnt_d   = WS_C;
          state_d = S_WAIT;
        end else if (memread & memwrite) begin
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          fault_d = fault_chk_s;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (acc_ok_s && !wr_q) begin
      readdata_d = load_extend(word_s, lane_s, size_q, uns_q);
    end else begin
      readdata_d = readdata_q;
    end
    ready_d = (state_d == S_RESP);
  end

  // State and output registers; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      readdata_q <= 32'h0000_0000;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign readdata = readdata_q;
  assign ready    = ready_q;
  assign fault    = fault_q;

endmodule
